// File: rtl/uart_mmio_fifo_if.sv
// Bus bundle for uart_mmio_fifo: the CPU mem_valid/mem_ready handshake.
//   mem_valid  request, qualified by the top-level address decode, held until mem_ready
//   mem_ready  one-cycle completion pulse
//   mem_addr   byte address; bits [3:2] select the register
//   mem_wdata  write data
//   mem_wstrb  write strobes; 4'b0000 = read
//   mem_rdata  read data, valid while mem_ready=1
// master: the CPU side; slave: the peripheral side.
interface uart_mmio_fifo_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/uart_mmio_fifo.sv
// uart_mmio_fifo: memory-mapped UART with TX/RX FIFOs, status register and
// sticky error flags, wrapped around the 8N1 `uart` core defined below.
// Ports:
//   clk, reset_n  clock; synchronous active-low reset (core gets rst = !reset_n)
//   bus           uart_mmio_fifo_if.slave: mem_valid/ready/addr/wdata/wstrb/rdata
//   rx, tx        serial line
//   irq           interrupt, present only when UART_MMIO_IRQ_EN is defined
// Registers (mem_addr[3:2]): 0 DATA, 1 STATUS, 2 CTRL (only with UART_MMIO_IRQ_EN), 3 unmapped.
// Parameters: TX_DEPTH, RX_DEPTH (powers of 2, >=2); CLKS_PER_BIT sets the line rate (>=2).

// uart: 8N1 serial core. transmit starts a frame when idle; received or
// recv_error pulses for one cycle at the middle of the stop bit.
module uart #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  input  logic       transmit,
  input  logic [7:0] tx_byte,
  output logic       received,
  output logic [7:0] rx_byte,
  output logic       is_receiving,
  output logic       is_transmitting,
  output logic       recv_error
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

  logic [9:0]    tx_shift;
  logic [3:0]    tx_bits, rx_bits;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic          tx_busy, rx_busy, rx_meta, rx_s, rx_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= '1;
      tx_bits  <= '0;
      tx_cnt   <= '0;
      tx_busy  <= 1'b0;
    end else if (!tx_busy) begin
      if (transmit) begin
        tx_shift <= {1'b1, tx_byte, 1'b0};
        tx_bits  <= '0;
        tx_cnt   <= '0;
        tx_busy  <= 1'b1;
      end
    end else if (tx_cnt == BIT_END) begin
      tx_cnt   <= '0;
      tx_shift <= {1'b1, tx_shift[9:1]};
      if (tx_bits == 4'd9) tx_busy <= 1'b0;
      else                 tx_bits <= tx_bits + 4'd1;
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  assign tx              = tx_busy ? tx_shift[0] : 1'b1;
  assign is_transmitting = tx_busy;
  assign is_receiving    = rx_busy;

  // A frame starts only on a falling edge, so a line held low after a
  // framing error does not retrigger reception.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      rx_prev    <= 1'b1;
      rx_busy    <= 1'b0;
      rx_bits    <= '0;
      rx_cnt     <= '0;
      rx_byte    <= '0;
      received   <= 1'b0;
      recv_error <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      rx_prev    <= rx_s;
      received   <= 1'b0;
      recv_error <= 1'b0;
      if (!rx_busy) begin
        rx_cnt  <= '0;
        rx_bits <= '0;
        if (rx_prev && !rx_s) rx_busy <= 1'b1;
      end else if (rx_cnt != ((rx_bits == 4'd0) ? HALF_END : BIT_END)) begin
        rx_cnt <= rx_cnt + CW'(1);
      end else begin
        rx_cnt <= '0;
        if (rx_bits == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;
          else      rx_bits <= 4'd1;
        end else if (rx_bits != 4'd9) begin
          rx_byte <= {rx_s, rx_byte[7:1]};
          rx_bits <= rx_bits + 4'd1;
        end else begin
          rx_busy    <= 1'b0;
          received   <= rx_s;
          recv_error <= !rx_s;
        end
      end
    end
  end
endmodule

module uart_mmio_fifo #(
  parameter int unsigned TX_DEPTH     = 16,
  parameter int unsigned RX_DEPTH     = 16,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  uart_mmio_fifo_if.slave bus,
  input  logic            rx,
  output logic            tx
`ifdef UART_MMIO_IRQ_EN
  , output logic          irq
`endif
);
  localparam int unsigned TAW = $clog2(TX_DEPTH);
  localparam int unsigned RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_HI, WAIT_LO} tx_state_t;
  tx_state_t state, state_next;

  logic       transmit, received, recv_error, is_transmitting, is_receiving;
  logic [7:0] rx_byte, tx_byte;

  uart #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_core (
    .clk             (clk),
    .rst             (!reset_n),
    .rx              (rx),
    .tx              (tx),
    .transmit        (transmit),
    .tx_byte         (tx_byte),
    .received        (received),
    .rx_byte         (rx_byte),
    .is_receiving    (is_receiving),
    .is_transmitting (is_transmitting),
    .recv_error      (recv_error)
  );

  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TAW:0] tx_wp, tx_rp;
  logic [RAW:0] rx_wp, rx_rp, rx_used;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_busy;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[TAW] != tx_rp[TAW]) && (tx_wp[TAW-1:0] == tx_rp[TAW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[RAW] != rx_rp[RAW]) && (rx_wp[RAW-1:0] == rx_rp[RAW-1:0]);
  assign rx_used  = rx_wp - rx_rp;
  assign tx_busy  = (state != IDLE) || is_transmitting;

  // Bus decode. A pulse on mem_ready blocks acceptance for that cycle, so a
  // held mem_valid commits only once; a DATA write waits while TX is full.
  logic [1:0] sel;
  logic is_write, data_wr, accept, tx_push, tx_pop, rx_push, rx_pop;
  logic clr_ovr, clr_err, ovr_set, rx_overrun, rx_err;

  assign sel      = bus.mem_addr[3:2];
  assign is_write = |bus.mem_wstrb;
  assign data_wr  = (sel == 2'd0) && bus.mem_wstrb[0];
  assign accept   = bus.mem_valid && !bus.mem_ready && !(data_wr && tx_full);
  assign tx_push  = accept && data_wr;
  assign rx_pop   = accept && !is_write && (sel == 2'd0) && !rx_empty;
  assign clr_ovr  = accept && (sel == 2'd1) && bus.mem_wstrb[0] && bus.mem_wdata[4];
  assign clr_err  = accept && (sel == 2'd1) && bus.mem_wstrb[0] && bus.mem_wdata[5];
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign rx_push  = received && (!rx_full || rx_pop);
  assign ovr_set  = received && rx_full && !rx_pop;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[TAW-1:0]] <= bus.mem_wdata[7:0];
    if (rx_push) rx_mem[rx_wp[RAW-1:0]] <= rx_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_wp      <= '0;
      tx_rp      <= '0;
      rx_wp      <= '0;
      rx_rp      <= '0;
      rx_overrun <= 1'b0;
      rx_err     <= 1'b0;
      state      <= IDLE;
      tx_byte    <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + (TAW+1)'(1);
      if (tx_pop)  tx_rp <= tx_rp + (TAW+1)'(1);
      if (rx_push) rx_wp <= rx_wp + (RAW+1)'(1);
      if (rx_pop)  rx_rp <= rx_rp + (RAW+1)'(1);
      if (tx_pop)  tx_byte <= tx_mem[tx_rp[TAW-1:0]];
      rx_overrun <= ovr_set    | (rx_overrun & !clr_ovr);
      rx_err     <= recv_error | (rx_err & !clr_err);
      state      <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    transmit   = 1'b0;
    tx_pop     = 1'b0;
    unique case (state)
      IDLE: if (!tx_empty && !is_transmitting) begin
        tx_pop     = 1'b1;
        state_next = LOAD;
      end
      LOAD: begin
        transmit   = 1'b1;
        state_next = WAIT_HI;
      end
      WAIT_HI: if (is_transmitting)  state_next = WAIT_LO;
      WAIT_LO: if (!is_transmitting) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic [31:0] status, ctrl_rd, rd_data;
  // rx_count is 8 bits wide, so a full 256-entry RX FIFO reads back as 0.
  assign status = {16'h0, 8'(rx_used), 2'b00, rx_err, rx_overrun,
                   tx_busy, tx_empty, tx_full, !rx_empty};

`ifdef UART_MMIO_IRQ_EN
  logic [1:0] ctrl;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl <= '0;
      irq  <= 1'b0;
    end else begin
      if (accept && (sel == 2'd2) && bus.mem_wstrb[0]) ctrl <= bus.mem_wdata[1:0];
      irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_empty && !tx_busy);
    end
  end
  assign ctrl_rd = {30'h0, ctrl};
`else
  assign ctrl_rd = '0;
`endif

  always_comb begin
    rd_data = '0;
    unique case (sel)
      2'd0:    if (!rx_empty) rd_data = {24'h0, rx_mem[rx_rp[RAW-1:0]]};
      2'd1:    rd_data = status;
      2'd2:    rd_data = ctrl_rd;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= accept;
      bus.mem_rdata <= (accept && !is_write) ? rd_data : '0;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{bus.mem_addr, bus.mem_wdata, is_receiving};
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Bench for uart_mmio_fifo: bus accesses push expected read data into a
// scoreboard queue checked by a ready monitor; DATA writes push expected
// bytes checked by a serial-line decoder on tx. RX state is modelled with a
// byte queue plus sticky flags. Define UART_MMIO_IRQ_EN to exercise irq.
module tb_uart_mmio_fifo;
  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned FRAME = 10 * CPB + 6;

  logic clk, reset_n, rx, tx;
`ifdef UART_MMIO_IRQ_EN
  logic irq;
`endif
  uart_mmio_fifo_if bus();

  uart_mmio_fifo #(.TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .rx      (rx),
    .tx      (tx)
`ifdef UART_MMIO_IRQ_EN
    , .irq   (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] exp; bit chk; string name; } exp_t;
  exp_t        bus_q[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  rxq[$];
  bit          m_ovr, m_err;
  int unsigned checks = 0, failures = 0, epoch = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endfunction

  // Expected STATUS with the transmitter drained.
  function automatic logic [31:0] st_idle();
    return {16'h0, 8'(rxq.size()), 2'b00, m_err, m_ovr, 1'b0, 1'b1, 1'b0, rxq.size() != 0};
  endfunction

  // Bus response monitor.
  always @(negedge clk) begin
    if (reset_n && bus.mem_ready === 1'b1) begin
      if (bus_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_ready actual=1 required=0");
      end else begin
        exp_t e;
        e = bus_q.pop_front();
        if (e.chk) check(e.name, bus.mem_rdata, e.exp);
      end
    end
  end

  // Serial decoder on tx; frames cut short by a reset are discarded.
  initial begin
    logic [7:0] b;
    logic stop;
    int unsigned ep;
    forever begin
      @(negedge clk);
      if (tx !== 1'b0) continue;
      ep = epoch;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = tx;
      end
      repeat (CPB) @(negedge clk);
      stop = tx;
      if (ep != epoch) continue;
      if (tx_exp.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected_byte actual=0x%02h required=none", b);
      end else begin
        check("tx_byte", {24'h0, b}, {24'h0, tx_exp.pop_front()});
        check("tx_stop", 32'(stop), 32'd1);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Called and returning at posedge+1.
  task automatic bus_access(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] wstrb, input logic [31:0] exp,
                            input bit chk, input string name, output int unsigned lat);
    bit done;
    done = 0;
    lat  = 0;
    bus_q.push_back('{exp, chk, name});
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = wstrb;
    bus.mem_valid = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.mem_ready === 1'b1) begin
        done = 1;
        break;
      end
    end
    bus.mem_valid = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ready required=ready", name);
      void'(bus_q.pop_back());
    end
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
    int unsigned l;
    bus_access(addr, 32'h0, 4'h0, exp, 1, name, l);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    int unsigned l;
    bus_access(addr, data, 4'hF, 32'h0, 0, "wr", l);
  endtask

  task automatic wr_data(input logic [7:0] b, output int unsigned lat);
    logic [31:0] w;
    w = $urandom;
    w[7:0] = b;
    tx_exp.push_back(b);
    bus_access(32'h0, w, ($urandom_range(0, 1) != 0) ? 4'h1 : 4'hF, 32'h0, 0, "wr_data", lat);
  endtask

  task automatic inject(input logic [7:0] b, input bit good);
    logic [9:0] f;
    f = {good, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = 1'b1;
    if (!good) begin
      repeat (2 * CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_received(output bit ok);
    ok = 0;
    for (int c = 0; c < 20 * CPB; c++) begin
      @(posedge clk);
      #1;
      if (dut.u_core.received === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL received_timeout actual=none required=pulse");
    end
  endtask

  initial begin
    int unsigned lat, n, m;
    logic [7:0] b;
    bit ok;
    reset_n = 1'b0;
    rx = 1'b1;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_ready", 32'(bus.mem_ready), 32'd0);
    check("reset_rdata", bus.mem_rdata, 32'd0);
    check("reset_tx", 32'(tx), 32'd1);
    reset_n = 1'b1;
    cycles(2);

    rd(32'h4, 32'h4, "status_after_reset");
    rd(32'h0, 32'h0, "data_read_empty");
    wr(32'hC, 32'hFFFF_FFFF);
    rd(32'hC, 32'h0, "unmapped_read");
`ifndef UART_MMIO_IRQ_EN
    wr(32'h8, 32'h3);
    rd(32'h8, 32'h0, "ctrl_absent");
`endif

    // Two bytes in order; the second waits in the FIFO behind the first.
    wr_data(8'h41, lat);
    wr_data(8'h42, lat);
    rd(32'h4, 32'h8, "status_busy");
    cycles(2 * FRAME + 20);
    rd(32'h4, st_idle(), "status_tx_done");

    // One byte moves into the transmitter, 16 fill the FIFO, the next stalls.
    for (int i = 0; i < DEPTH + 1; i++) wr_data(8'($urandom), lat);
    rd(32'h4, 32'hA, "status_tx_full");
    wr_data(8'($urandom), lat);
    check("tx_full_stall", 32'(lat > 10), 32'd1);
    cycles((DEPTH + 2) * FRAME + 20);
    rd(32'h4, st_idle(), "status_tx_drained");

    // RX overflow: 17 bytes, the last dropped.
    for (int i = 1; i <= DEPTH + 1; i++) begin
      inject(8'(i), 1);
      if (rxq.size() < DEPTH) rxq.push_back(8'(i));
      else m_ovr = 1;
    end
    cycles(4);
    rd(32'h4, st_idle(), "status_rx_overrun");
    wr(32'h4, 32'h10);
    m_ovr = 0;
    rd(32'h4, st_idle(), "status_ovr_cleared");

    // Clear landing with a new overrun: the set wins.
    fork
      inject(8'hEE, 1);
      begin
        wait_received(ok);
        wr(32'h4, 32'h10);
      end
    join
    m_ovr = 1;
    rd(32'h4, st_idle(), "status_set_beats_clear");
    wr(32'h4, 32'h10);
    m_ovr = 0;
    rd(32'h4, st_idle(), "status_ovr_cleared2");

    // Pop and push together on a full FIFO: both happen, no overrun.
    fork
      inject(8'h99, 1);
      begin
        logic [7:0] e;
        wait_received(ok);
        e = rxq.pop_front();
        rd(32'h0, {24'h0, e}, "rx_pop_while_full");
      end
    join
    rxq.push_back(8'h99);
    rd(32'h4, st_idle(), "status_full_no_overrun");
    while (rxq.size() != 0) rd(32'h0, {24'h0, rxq.pop_front()}, "rx_data");
    rd(32'h0, 32'h0, "rx_read_empty");
    rd(32'h4, st_idle(), "status_rx_empty");

    // Framing error sets rx_err without pushing.
    inject(8'h5A, 0);
    m_err = 1;
    rd(32'h4, st_idle(), "status_rx_err");
    wr(32'h4, 32'h20);
    m_err = 0;
    rd(32'h4, st_idle(), "status_err_cleared");

    // Randomized mixed traffic.
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int i = 0; i < int'(n); i++) wr_data(8'($urandom), lat);
      m = $urandom_range(0, 5);
      for (int i = 0; i < int'(m); i++) begin
        b = 8'($urandom);
        inject(b, 1);
        rxq.push_back(b);
      end
      rd(32'h0000_000C | ($urandom & 32'hFFFF_FFF0), 32'h0, "rand_unmapped");
      cycles(n * FRAME + 20);
      rd(32'h4, st_idle(), "rand_status");
      while (rxq.size() != 0) rd(32'h0, {24'h0, rxq.pop_front()}, "rand_rx_data");
      rd(32'h0, 32'h0, "rand_rx_empty");
    end

    // Reset while transmitting with three bytes queued.
    for (int i = 0; i < 4; i++) wr_data(8'($urandom), lat);
    cycles(3 * CPB);
    reset_n = 1'b0;
    epoch++;
    tx_exp.delete();
    cycles(1);
    check("midreset_ready", 32'(bus.mem_ready), 32'd0);
    check("midreset_tx", 32'(tx), 32'd1);
    reset_n = 1'b1;
    rd(32'h4, 32'h4, "status_after_midreset");
    cycles(12 * CPB);

`ifdef UART_MMIO_IRQ_EN
    wr(32'h8, 32'h1);
    rd(32'h8, 32'h1, "ctrl_readback");
    inject(8'h55, 1);
    check("irq_rx_set", 32'(irq), 32'd1);
    rd(32'h0, 32'h55, "irq_rx_data");
    cycles(2);
    check("irq_rx_clear", 32'(irq), 32'd0);
    wr(32'h8, 32'h2);
    cycles(2);
    check("irq_txe_set", 32'(irq), 32'd1);
    wr(32'h8, 32'h0);
    cycles(2);
    check("irq_disabled", 32'(irq), 32'd0);
`endif

    cycles(20);
    check("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    check("tx_queue_empty", 32'(tx_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
